// File: rtl/velocity_to_segment.sv
// Purpose: turns one Q16.16 velocity (vx, vy) at origin (x0, y0) into a unit direction plus segment length.
// Latency: 50 cycles from input handshake to out_valid (33 for a zero vector); only one vector in flight.
// Backpressure: in_ready is high only when idle; the result is held in DONE until out_ready.
module velocity_to_segment #(
    parameter int unsigned LEN_SHIFT = 0,
    parameter logic [31:0] MAX_LEN   = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x0_in,
    input  logic [31:0] y0_in,
    input  logic [31:0] vx_in,
    input  logic [31:0] vy_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x0,
    output logic [31:0] y0,
    output logic [31:0] xn,
    output logic [31:0] yn,
    output logic [31:0] mag
);

    typedef enum logic [2:0] {IDLE, SQR, SQRT, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] ax, ay;
    logic        sx, sy;
    logic [63:0] sum_sh;
    logic [35:0] rem_s;
    logic [31:0] root;
    logic [4:0]  cnt;
    logic [31:0] rem_x, rem_y;
    logic [16:0] dsh_x, dsh_y;
    logic [16:0] qx, qy;

    // Input magnitudes; 0x8000_0000 maps to 2^31, which still fits unsigned.
    logic [31:0] abs_vx, abs_vy;
    assign abs_vx = vx_in[31] ? (~vx_in + 32'd1) : vx_in;
    assign abs_vy = vy_in[31] ? (~vy_in + 32'd1) : vy_in;

    logic [63:0] sq_sum;
    assign sq_sum = ({32'd0, ax} * {32'd0, ax}) + ({32'd0, ay} * {32'd0, ay});

    // One square-root step: bring in two bits of the radicand, try (root<<2)|1.
    logic [35:0] rem_s_sh, trial, rem_s_nx;
    logic        s_ge;
    logic [31:0] root_nx;
    assign rem_s_sh = {rem_s[33:0], sum_sh[63:62]};
    assign trial    = {2'b00, root, 2'b01};
    assign s_ge     = (rem_s_sh >= trial);
    assign rem_s_nx = s_ge ? (rem_s_sh - trial) : rem_s_sh;
    assign root_nx  = {root[30:0], s_ge};

    // Divider steps; the top 31 dividend bits start in the remainder since the quotient is 17 bits.
    logic [32:0] tx, ty, dx, dy;
    logic        x_ge, y_ge;
    logic [16:0] qx_nx, qy_nx;
    assign tx    = {rem_x, dsh_x[16]};
    assign ty    = {rem_y, dsh_y[16]};
    assign x_ge  = (tx >= {1'b0, root});
    assign y_ge  = (ty >= {1'b0, root});
    assign dx    = x_ge ? (tx - {1'b0, root}) : tx;
    assign dy    = y_ge ? (ty - {1'b0, root}) : ty;
    assign qx_nx = {qx[15:0], x_ge};
    assign qy_nx = {qy[15:0], y_ge};

    logic [31:0] root_shr, mag_nx;
    assign root_shr = root >> LEN_SHIFT;
    assign mag_nx   = (root_shr > MAX_LEN) ? MAX_LEN : root_shr;

    function automatic logic [31:0] signed_q(input logic neg, input logic [16:0] q);
        logic [31:0] ext;
        ext = {15'd0, q};
        return neg ? (~ext + 32'd1) : ext;
    endfunction

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            x0        <= '0;
            y0        <= '0;
            xn        <= '0;
            yn        <= '0;
            mag       <= '0;
            ax        <= '0;
            ay        <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            sum_sh    <= '0;
            rem_s     <= '0;
            root      <= '0;
            cnt       <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            dsh_x     <= '0;
            dsh_y     <= '0;
            qx        <= '0;
            qy        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0    <= x0_in;
                        y0    <= y0_in;
                        ax    <= abs_vx;
                        ay    <= abs_vy;
                        sx    <= vx_in[31];
                        sy    <= vy_in[31];
                        state <= SQR;
                    end
                end
                SQR: begin
                    sum_sh <= sq_sum;
                    rem_s  <= '0;
                    root   <= '0;
                    cnt    <= '0;
                    state  <= SQRT;
                end
                SQRT: begin
                    sum_sh <= {sum_sh[61:0], 2'b00};
                    rem_s  <= rem_s_nx;
                    root   <= root_nx;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        cnt <= '0;
                        if (root_nx == 32'd0) begin
                            xn        <= '0;
                            yn        <= '0;
                            mag       <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem_x <= {1'b0, ax[31:1]};
                            rem_y <= {1'b0, ay[31:1]};
                            dsh_x <= {ax[0], 16'd0};
                            dsh_y <= {ay[0], 16'd0};
                            qx    <= '0;
                            qy    <= '0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_x <= dx[31:0];
                    rem_y <= dy[31:0];
                    dsh_x <= {dsh_x[15:0], 1'b0};
                    dsh_y <= {dsh_y[15:0], 1'b0};
                    qx    <= qx_nx;
                    qy    <= qy_nx;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd16) begin
                        xn        <= signed_q(sx, qx_nx);
                        yn        <= signed_q(sy, qy_nx);
                        mag       <= mag_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_to_segment.sv
// Directed vector table plus backpressure and mid-operation reset sequences for velocity_to_segment.
module tb_velocity_to_segment;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] x0_in, y0_in, vx_in, vy_in;
    logic        in_ready, out_valid;
    logic [31:0] x0, y0, xn, yn, mag;
    logic        in_ready2, out_valid2;
    logic [31:0] x0_2, y0_2, xn2, yn2, mag2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    velocity_to_segment dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0_in(x0_in), .y0_in(y0_in), .vx_in(vx_in), .vy_in(vy_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0(x0), .y0(y0), .xn(xn), .yn(yn), .mag(mag)
    );

    velocity_to_segment #(.LEN_SHIFT(4), .MAX_LEN(32'h0010_0000)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x0_in(x0_in), .y0_in(y0_in), .vx_in(vx_in), .vy_in(vy_in),
        .out_valid(out_valid2), .out_ready(out_ready),
        .x0(x0_2), .y0(y0_2), .xn(xn2), .yn(yn2), .mag(mag2)
    );

    typedef struct {
        logic [31:0] vx, vy, x0, y0;
        logic [31:0] xn, yn, mag, mag2;
        int          lat;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector, clock the accepting edge, then count edges until out_valid.
    task automatic run_vec(input vec_t v, output int lat);
        vx_in    = v.vx;
        vy_in    = v.vy;
        x0_in    = v.x0;
        y0_in    = v.y0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t v, input int lat);
        chk({tag, ".lat"}, lat, v.lat);
        chk({tag, ".xn"}, xn, v.xn);
        chk({tag, ".yn"}, yn, v.yn);
        chk({tag, ".mag"}, mag, v.mag);
        chk({tag, ".x0"}, x0, v.x0);
        chk({tag, ".y0"}, y0, v.y0);
        chk({tag, ".mag_shift4"}, mag2, v.mag2);
    endtask

    initial begin
        int lat;
        int stale;

        vt[0] = '{32'h0003_0000, 32'h0004_0000, 32'h000A_0000, 32'h0014_0000,
                  32'h0000_9999, 32'h0000_CCCC, 32'h0005_0000, 32'h0000_5000, 50};
        vt[1] = '{32'hFFFD_0000, 32'hFFFC_0000, 32'hFFF6_0000, 32'h0001_0000,
                  32'hFFFF_6667, 32'hFFFF_3334, 32'h0005_0000, 32'h0000_5000, 50};
        vt[2] = '{32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'h8765_4321,
                  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 33};
        vt[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0005_0000, 32'h0006_0000,
                  32'h0000_B504, 32'h0000_B504, 32'h7FFF_FFFF, 32'h0010_0000, 50};
        vt[4] = '{32'h0001_0000, 32'h0000_0000, 32'h0007_0000, 32'h0008_0000,
                  32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_1000, 50};
        vt[5] = '{32'h0000_0000, 32'hFFFE_0000, 32'h0009_0000, 32'h000B_0000,
                  32'h0000_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0000_2000, 50};
        vt[6] = '{32'h8000_0000, 32'h0000_0000, 32'h000C_0000, 32'h000D_0000,
                  32'hFFFF_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0010_0000, 50};
        vt[7] = '{32'h0000_0001, 32'h0000_0000, 32'h000E_0000, 32'h000F_0000,
                  32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 50};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x0_in     = '0;
        y0_in     = '0;
        vx_in     = '0;
        vy_in     = '0;
        repeat (3) tick();
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.mag", mag, 0);
        chk("rst.xn", xn, 0);
        chk("rst.yn", yn, 0);
        chk("rst.x0", x0, 0);
        chk("rst.y0", y0, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d.in_ready", i), in_ready, 1);
            run_vec(vt[i], lat);
            chk_vec($sformatf("v%0d", i), vt[i], lat);
            tick();
            chk($sformatf("v%0d.valid_drop", i), out_valid, 0);
            chk($sformatf("v%0d.ready_back", i), in_ready, 1);
        end

        // Hold the result for 20 cycles while a second input pulse is offered.
        out_ready = 1'b0;
        run_vec(vt[0], lat);
        chk("bp.lat", lat, 50);
        for (int j = 0; j < 20; j++) begin
            if (j == 5) begin
                vx_in    = 32'h0001_0000;
                vy_in    = 32'h0000_0000;
                x0_in    = 32'hDEAD_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp.out_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
            chk("bp.xn", xn, vt[0].xn);
            chk("bp.yn", yn, vt[0].yn);
            chk("bp.mag", mag, vt[0].mag);
            chk("bp.x0", x0, vt[0].x0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp.release_valid", out_valid, 0);
        chk("bp.release_ready", in_ready, 1);
        run_vec(vt[4], lat);
        chk_vec("b2b", vt[4], lat);
        tick();

        // Reset ten cycles into the square root.
        run_vec_start: begin
            vx_in    = vt[0].vx;
            vy_in    = vt[0].vy;
            x0_in    = vt[0].x0;
            y0_in    = vt[0].y0;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        repeat (10) tick();
        chk("mid.in_ready_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid.in_ready", in_ready, 1);
        chk("mid.out_valid", out_valid, 0);
        chk("mid.x0", x0, 0);
        chk("mid.mag", mag, 0);
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("mid.stale_valid", stale, 0);
        run_vec(vt[1], lat);
        chk_vec("fresh", vt[1], lat);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
